// File: rtl/multi_mult_add.sv
// multi_mult_add: N-term signed multiply-add with accumulator,
// round-half-up output shift and saturation, fixed latency 4+clog2(N).
module multi_mult_add #(
  parameter int N   = 2,
  parameter int NBA = 25,
  parameter int NBB = 18,
  parameter int NBP = 48,
  parameter int S   = 0,
  parameter int NG  = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ce,
  input  logic             in_valid,
  input  logic             acc,
  input  logic [N-1:0]     sub,
  input  logic [N*NBA-1:0] a,
  input  logic [N*NBB-1:0] b,
  output logic [NBP-1:0]   p,
  output logic             out_valid,
  output logic             sat
);

  localparam int WP = NBA + NBB;
  localparam int T  = (N > 1) ? $clog2(N) : 0;
  localparam int WA = WP + T + NG;
  localparam int WR = WA + 1;
  localparam int WX = ((WR > NBP) ? WR : NBP) + 1;
  localparam int SH = (S > 0) ? S - 1 : 0;

  localparam logic signed [WR-1:0] RND =
    (S > 0) ? (WR'(1) <<< SH) : WR'(0);
  localparam logic signed [WX-1:0] PMAX =
    (WX'(1) <<< (NBP - 1)) - WX'(1);
  localparam logic signed [WX-1:0] PMIN =
    -PMAX - WX'(1);

  // number of live nodes at tree level l
  function automatic int cnt(input int l);
    return (N + (1 << l) - 1) >> l;
  endfunction

  logic             v1_q, v1_d;
  logic             acc1_q, acc1_d;
  logic [N-1:0]     sub1_q, sub1_d;
  logic [N*NBA-1:0] a1_q, a1_d;
  logic [N*NBB-1:0] b1_q, b1_d;

  logic signed [WA-1:0] lvl_q [0:T][0:N-1];
  logic signed [WA-1:0] lvl_d [0:T][0:N-1];
  logic [T:0]           vld_q, vld_d;
  logic [T:0]           accp_q, accp_d;

  logic                 av_q, av_d;
  logic signed [WA-1:0] acc_reg_q, acc_reg_d;

  logic                 ov_q, ov_d;
  logic [NBP-1:0]       p_q, p_d;
  logic                 sat_q, sat_d;

  logic signed [WR-1:0] rnd;
  logic signed [WR-1:0] shf;
  logic signed [WX-1:0] ext;

  // stage 1: capture the input beat
  always_comb begin
    v1_d   = in_valid;
    acc1_d = acc;
    sub1_d = sub;
    a1_d   = a;
    b1_d   = b;
  end

  // stage 2 products and adder tree levels
  always_comb begin
    logic signed [WA-1:0] ea;
    logic signed [WA-1:0] eb;
    logic signed [WA-1:0] pr;
    int                   hi;
    lvl_d  = '{default: '0};
    vld_d  = '0;
    accp_d = '0;
    vld_d[0]  = v1_q;
    accp_d[0] = acc1_q;
    for (int k = 0; k < N; k++) begin
      ea = $signed(a1_q[k*NBA +: NBA]);
      eb = $signed(b1_q[k*NBB +: NBB]);
      pr = ea * eb;
      lvl_d[0][k] = sub1_q[k] ? -pr : pr;
    end
    for (int l = 1; l <= T; l++) begin
      vld_d[l]  = vld_q[l-1];
      accp_d[l] = accp_q[l-1];
      for (int j = 0; j < N; j++) begin
        hi = (2*j + 1 < N) ? 2*j + 1 : N - 1;
        if (j < cnt(l)) begin
          if (2*j + 1 < cnt(l - 1))
            lvl_d[l][j] = lvl_q[l-1][2*j]
                        + lvl_q[l-1][hi];
          else
            lvl_d[l][j] = lvl_q[l-1][2*j];
        end
      end
    end
  end

  // accumulator: load or add the tree sum on valid beats
  always_comb begin
    av_d      = vld_q[T];
    acc_reg_d = acc_reg_q;
    if (vld_q[T])
      acc_reg_d = (accp_q[T] ? acc_reg_q : '0)
                + lvl_q[T][0];
  end

  // output: round half up, shift, saturate
  always_comb begin
    rnd   = acc_reg_q;
    rnd   = rnd + RND;
    shf   = rnd >>> S;
    ext   = shf;
    ov_d  = av_q;
    p_d   = p_q;
    sat_d = sat_q;
    if (av_q) begin
      if (ext > PMAX) begin
        p_d   = PMAX[NBP-1:0];
        sat_d = 1'b1;
      end else if (ext < PMIN) begin
        p_d   = PMIN[NBP-1:0];
        sat_d = 1'b1;
      end else begin
        p_d   = ext[NBP-1:0];
        sat_d = 1'b0;
      end
    end
  end

  // all pipeline state advances only when ce is high
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v1_q      <= 1'b0;
      acc1_q    <= 1'b0;
      sub1_q    <= '0;
      a1_q      <= '0;
      b1_q      <= '0;
      lvl_q     <= '{default: '0};
      vld_q     <= '0;
      accp_q    <= '0;
      av_q      <= 1'b0;
      acc_reg_q <= '0;
      ov_q      <= 1'b0;
      p_q       <= '0;
      sat_q     <= 1'b0;
    end else if (ce) begin
      v1_q      <= v1_d;
      acc1_q    <= acc1_d;
      sub1_q    <= sub1_d;
      a1_q      <= a1_d;
      b1_q      <= b1_d;
      lvl_q     <= lvl_d;
      vld_q     <= vld_d;
      accp_q    <= accp_d;
      av_q      <= av_d;
      acc_reg_q <= acc_reg_d;
      ov_q      <= ov_d;
      p_q       <= p_d;
      sat_q     <= sat_d;
    end
  end

  assign p         = p_q;
  assign out_valid = ov_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_multi_mult_add.sv
// tb_multi_mult_add: two instances (N=2 full width, N=4 with
// 16-bit rounded/saturated output) against a scoreboard model.
module tb_multi_mult_add;

  localparam int NBA  = 25;
  localparam int NBB  = 18;
  localparam int NG   = 8;
  localparam int N1   = 2;
  localparam int NBP1 = 48;
  localparam int S1   = 0;
  localparam int L1   = 5;
  localparam int N2   = 4;
  localparam int NBP2 = 16;
  localparam int S2   = 4;
  localparam int L2   = 6;

  typedef struct {
    longint p;
    bit     s;
    int     due;
  } exp_t;

  logic clock, reset_n, ce, in_valid, acc;
  logic [N1-1:0]     sub1;
  logic [N1*NBA-1:0] a1;
  logic [N1*NBB-1:0] b1;
  logic [NBP1-1:0]   p1;
  logic              ov1, sat1;
  logic [N2-1:0]     sub2;
  logic [N2*NBA-1:0] a2;
  logic [N2*NBB-1:0] b2;
  logic [NBP2-1:0]   p2;
  logic              ov2, sat2;

  exp_t   q1[$];
  exp_t   q2[$];
  longint m1, m2;
  int     ecnt;
  int     n_vec, n_bad;
  logic   pov1, pov2;

  multi_mult_add #(
    .N(N1), .NBA(NBA), .NBB(NBB),
    .NBP(NBP1), .S(S1), .NG(NG)
  ) u1 (
    .clock(clock), .reset_n(reset_n), .ce(ce),
    .in_valid(in_valid), .acc(acc), .sub(sub1),
    .a(a1), .b(b1), .p(p1),
    .out_valid(ov1), .sat(sat1)
  );

  multi_mult_add #(
    .N(N2), .NBA(NBA), .NBB(NBB),
    .NBP(NBP2), .S(S2), .NG(NG)
  ) u2 (
    .clock(clock), .reset_n(reset_n), .ce(ce),
    .in_valid(in_valid), .acc(acc), .sub(sub2),
    .a(a2), .b(b2), .p(p2),
    .out_valid(ov2), .sat(sat2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void chk(input string nm,
                              input longint got,
                              input longint exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               nm, got, exp, $time);
    end
  endfunction

  function automatic longint dot(
    input int n,
    input logic [4*NBA-1:0] av,
    input logic [4*NBB-1:0] bv,
    input logic [3:0] sv);
    longint s, x, y;
    s = 0;
    for (int k = 0; k < n; k++) begin
      x = longint'($signed(av[k*NBA +: NBA]));
      y = longint'($signed(bv[k*NBB +: NBB]));
      s += sv[k] ? -(x * y) : x * y;
    end
    return s;
  endfunction

  function automatic void outv(input longint v,
                               input int s,
                               input int nbp,
                               output longint pe,
                               output bit se);
    longint r, hi, lo, t;
    r  = (s > 0) ? (longint'(1) <<< (s - 1)) : 0;
    t  = (v + r) >>> s;
    hi = (longint'(1) <<< (nbp - 1)) - 1;
    lo = -hi - 1;
    se = (t > hi) || (t < lo);
    pe = (t > hi) ? hi : ((t < lo) ? lo : t);
  endfunction

  function automatic longint rval(input int w);
    longint x;
    if ($urandom_range(0, 1) == 1)
      return longint'($urandom_range(0, 4000)) - 2000;
    x = longint'($urandom);
    x = (x << (64 - w)) >>> (64 - w);
    return x;
  endfunction

  task automatic put1(input int k, input longint av,
                      input longint bv);
    a1[k*NBA +: NBA] = NBA'(av);
    b1[k*NBB +: NBB] = NBB'(bv);
  endtask

  task automatic put2(input int k, input longint av,
                      input longint bv);
    a2[k*NBA +: NBA] = NBA'(av);
    b2[k*NBB +: NBB] = NBB'(bv);
  endtask

  task automatic clr_data();
    a1 = '0; b1 = '0; sub1 = '0;
    a2 = '0; b2 = '0; sub2 = '0;
  endtask

  task automatic rnd_data();
    for (int k = 0; k < N1; k++)
      put1(k, rval(NBA), rval(NBB));
    for (int k = 0; k < N2; k++)
      put2(k, rval(NBA), rval(NBB));
    sub1 = N1'($urandom);
    sub2 = N2'($urandom);
  endtask

  task automatic set_sum(input longint v);
    clr_data();
    put1(0, v, 1);
    put2(0, v, 1);
  endtask

  // one clock: drive, wait for the edge, record accepted beats
  task automatic cyc(input bit v, input bit ac, input bit c);
    longint pe;
    bit     se;
    in_valid = v;
    acc      = ac;
    ce       = c;
    @(posedge clock);
    if (c && reset_n) begin
      ecnt++;
      if (v) begin
        m1 = (ac ? m1 : 0)
           + dot(N1, (4*NBA)'(a1), (4*NBB)'(b1), 4'(sub1));
        outv(m1, S1, NBP1, pe, se);
        q1.push_back('{pe, se, ecnt + L1 - 1});
        m2 = (ac ? m2 : 0) + dot(N2, a2, b2, sub2);
        outv(m2, S2, NBP2, pe, se);
        q2.push_back('{pe, se, ecnt + L2 - 1});
      end
    end
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ov1"}, longint'(ov1), 0);
    chk({tag, "_p1"}, longint'($signed(p1)), 0);
    chk({tag, "_sat1"}, longint'(sat1), 0);
    chk({tag, "_ov2"}, longint'(ov2), 0);
    chk({tag, "_p2"}, longint'($signed(p2)), 0);
    chk({tag, "_sat2"}, longint'(sat2), 0);
  endtask

  // monitor for instance 1
  initial begin
    bit   en;
    int   mc;
    exp_t e;
    mc   = 0;
    pov1 = 1'b0;
    forever begin
      @(posedge clock);
      en = ce && reset_n;
      if (en) mc++;
      #1;
      if (!en) begin
        chk("ov1_hold", longint'(ov1), longint'(pov1));
      end else if (ov1) begin
        chk("q1_pending", longint'(q1.size() > 0), 1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          chk("p1", longint'($signed(p1)), e.p);
          chk("sat1", longint'(sat1), longint'(e.s));
          chk("lat1", longint'(mc), longint'(e.due));
        end
      end
      pov1 = ov1;
    end
  end

  // monitor for instance 2
  initial begin
    bit   en;
    int   mc;
    exp_t e;
    mc   = 0;
    pov2 = 1'b0;
    forever begin
      @(posedge clock);
      en = ce && reset_n;
      if (en) mc++;
      #1;
      if (!en) begin
        chk("ov2_hold", longint'(ov2), longint'(pov2));
      end else if (ov2) begin
        chk("q2_pending", longint'(q2.size() > 0), 1);
        if (q2.size() > 0) begin
          e = q2.pop_front();
          chk("p2", longint'($signed(p2)), e.p);
          chk("sat2", longint'(sat2), longint'(e.s));
          chk("lat2", longint'(mc), longint'(e.due));
        end
      end
      pov2 = ov2;
    end
  end

  initial begin
    int  tries;
    bit  c;
    n_vec = 0; n_bad = 0;
    m1 = 0; m2 = 0; ecnt = 0;
    reset_n = 1'b0; ce = 1'b0;
    in_valid = 1'b0; acc = 1'b0;
    clr_data();
    repeat (3) @(posedge clock);
    #1;
    chk_zero("reset");
    reset_n = 1'b1;
    cyc(0, 0, 1);

    // two-term and four-term add/subtract mix
    clr_data();
    put1(0, -3, 5); put1(1, 100, 7);
    sub1 = 2'b10;
    for (int k = 0; k < N2; k++) put2(k, 1000, k + 1);
    sub2 = 4'b0101;
    cyc(1, 1, 1);
    repeat (8) cyc(0, 0, 1);

    // rounding and clipping, back to back
    set_sum(24);  cyc(1, 0, 1);
    set_sum(23);  cyc(1, 0, 1);
    clr_data();
    put1(0, 1 << 20, 32); put2(0, 1 << 20, 32);
    cyc(1, 0, 1);
    clr_data();
    put1(0, -(1 << 20), 32); put2(0, -(1 << 20), 32);
    cyc(1, 0, 1);
    repeat (8) cyc(0, 0, 1);

    // accumulate with junk invalid beats in between
    set_sum(10); cyc(1, 0, 1);
    rnd_data();  cyc(0, 1, 1);
    set_sum(10); cyc(1, 1, 1);
    rnd_data();  cyc(0, 0, 1);
    rnd_data();  cyc(0, 1, 1);
    set_sum(10); cyc(1, 1, 1);
    set_sum(5);  cyc(1, 0, 1);
    repeat (8) cyc(0, 0, 1);

    // ce stall while streaming
    for (int i = 0; i < 8; i++) begin
      rnd_data();
      tries = 0;
      do begin
        c = ($urandom_range(0, 1) == 1) || (tries > 20);
        cyc(1, 1'($urandom), c);
        tries++;
      end while (!c);
    end
    repeat (20) cyc(0, 0, 1'($urandom));
    repeat (8) cyc(0, 0, 1);

    // asynchronous reset with beats in flight
    set_sum(10);
    cyc(1, 0, 1); cyc(1, 1, 1); cyc(1, 1, 1);
    cyc(0, 0, 1);
    #2 reset_n = 1'b0;
    #1 chk_zero("midrst");
    q1.delete(); q2.delete();
    m1 = 0; m2 = 0;
    pov1 = 1'b0; pov2 = 1'b0;
    #2 reset_n = 1'b1;
    set_sum(7); cyc(1, 1, 1);
    repeat (8) cyc(0, 0, 1);

    // random stream
    repeat (400) begin
      rnd_data();
      cyc($urandom_range(0, 3) != 0,
          1'($urandom_range(0, 1)),
          $urandom_range(0, 7) != 0);
    end
    repeat (12) cyc(0, 0, 1);

    chk("q1_drained", longint'(q1.size()), 0);
    chk("q2_drained", longint'(q2.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
